// File: rtl/mips_muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO registers; one shared shift/add-subtract datapath.
// Optional feature: define MULDIV_MADD_EN to make op 110/111 accumulate a product into {hi,lo}.
module mips_muldiv_unit #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int N  = WIDTH / BITS_PER_CYCLE;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2, FIX = 2'd3} state_t;

    function automatic logic [WIDTH-1:0] condNeg(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? ({WIDTH{1'b0}} - v) : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] condNeg2(input logic [2*WIDTH-1:0] v, input logic neg);
        return neg ? ({(2*WIDTH){1'b0}} - v) : v;
    endfunction

    state_t               stateR, stateNext;
    logic [CW-1:0]        cntR;
    logic [2*WIDTH-1:0]   accR;
    logic [WIDTH-1:0]     opdR, rsRawR, hiR, loR;
    logic                 negAR, negBR, divZeroR, isDivR, isMaddR, busyR, doneR;

    logic                 isMulS, isDivS, isMaddS, signedS, acceptS, negAS, negBS;
    logic [WIDTH-1:0]     absAS, absBS;
    logic [2*WIDTH-1:0]   stepS, prodS;
    logic [WIDTH:0]       rem2S, sumS;
    logic [WIDTH-1:0]     remNewS, fixHiS, fixLoS;
    logic                 geS;

    // Opcode decode and operand magnitude/sign extraction at issue.
    always_comb begin
`ifdef MULDIV_MADD_EN
        isMaddS = (op[2:1] == 2'b11);
`else
        isMaddS = 1'b0;
`endif
        isMulS  = (op[2:1] == 2'b00) || isMaddS;
        isDivS  = (op[2:1] == 2'b01);
        signedS = ~op[0];
        acceptS = start && (stateR == IDLE) && !flush;
        negAS   = signedS && rs_val[WIDTH-1];
        negBS   = signedS && rt_val[WIDTH-1];
        absAS   = condNeg(rs_val, negAS);
        absBS   = condNeg(rt_val, negBS);
    end

    // One clock's worth of iterations: shift-add multiply or restoring divide on accR.
    always_comb begin
        stepS   = accR;
        rem2S   = {(WIDTH+1){1'b0}};
        sumS    = {(WIDTH+1){1'b0}};
        remNewS = {WIDTH{1'b0}};
        geS     = 1'b0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (isDivR) begin
                rem2S   = {stepS[2*WIDTH-1:WIDTH], stepS[WIDTH-1]};
                geS     = (rem2S >= {1'b0, opdR});
                remNewS = geS ? WIDTH'(rem2S - {1'b0, opdR}) : rem2S[WIDTH-1:0];
                stepS   = {remNewS, stepS[WIDTH-2:0], geS};
            end else begin
                sumS  = {1'b0, stepS[2*WIDTH-1:WIDTH]} + (stepS[0] ? {1'b0, opdR} : {(WIDTH+1){1'b0}});
                stepS = {sumS, stepS[WIDTH-1:1]};
            end
        end
    end

    // Sign fix-up and special divide results applied on the FIX edge.
    always_comb begin
        prodS = condNeg2(accR, negAR ^ negBR);
        if (isDivR) begin
            if (divZeroR) begin
                fixHiS = rsRawR;
                fixLoS = {WIDTH{1'b1}};
            end else begin
                fixHiS = condNeg(accR[2*WIDTH-1:WIDTH], negAR);
                fixLoS = condNeg(accR[WIDTH-1:0], negAR ^ negBR);
            end
        end else if (isMaddR) begin
            {fixHiS, fixLoS} = {hiR, loR} + prodS;
        end else begin
            {fixHiS, fixLoS} = prodS;
        end
    end

    // Next-state logic; flush always returns to IDLE and beats a simultaneous start.
    always_comb begin
        stateNext = stateR;
        case (stateR)
            IDLE: begin
                if (acceptS && isMulS) begin
                    stateNext = MUL;
                end else if (acceptS && isDivS) begin
                    stateNext = DIV;
                end else begin
                    stateNext = IDLE;
                end
            end
            MUL, DIV: begin
                if (flush) begin
                    stateNext = IDLE;
                end else if (cntR == CW'(1)) begin
                    stateNext = FIX;
                end else begin
                    stateNext = stateR;
                end
            end
            FIX:     stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // State register plus registered busy/done strobes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stateR <= IDLE;
            busyR  <= 1'b0;
            doneR  <= 1'b0;
        end else begin
            stateR <= stateNext;
            busyR  <= (stateNext != IDLE);
            doneR  <= (acceptS && (op[2:1] == 2'b10)) || ((stateR == FIX) && !flush);
        end
    end

    // Operand capture on accept, then one iteration step per clock while running.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cntR     <= {CW{1'b0}};
            accR     <= {(2*WIDTH){1'b0}};
            opdR     <= {WIDTH{1'b0}};
            rsRawR   <= {WIDTH{1'b0}};
            negAR    <= 1'b0;
            negBR    <= 1'b0;
            divZeroR <= 1'b0;
            isDivR   <= 1'b0;
            isMaddR  <= 1'b0;
        end else if (acceptS && (isMulS || isDivS)) begin
            cntR     <= CW'(N);
            accR     <= {{WIDTH{1'b0}}, (isDivS ? absAS : absBS)};
            opdR     <= isDivS ? absBS : absAS;
            rsRawR   <= rs_val;
            negAR    <= negAS;
            negBR    <= negBS;
            divZeroR <= (rt_val == {WIDTH{1'b0}});
            isDivR   <= isDivS;
            isMaddR  <= isMaddS;
        end else if ((stateR == MUL) || (stateR == DIV)) begin
            cntR <= cntR - CW'(1);
            accR <= stepS;
        end
    end

    // HI/LO architectural registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hiR <= {WIDTH{1'b0}};
            loR <= {WIDTH{1'b0}};
        end else if (acceptS && (op == 3'b100)) begin
            hiR <= rs_val;
        end else if (acceptS && (op == 3'b101)) begin
            loR <= rs_val;
        end else if ((stateR == FIX) && !flush) begin
            hiR <= fixHiS;
            loR <= fixLoS;
        end
    end

    assign busy = busyR;
    assign done = doneR;
    assign hi   = hiR;
    assign lo   = loR;
endmodule
